// File: rtl/key_led_pkg.sv
// Shared types for the key-driven LED pattern controller.
package key_led_pkg;

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'd0,
        MODE_WALK_L = 2'd1,
        MODE_WALK_R = 2'd2,
        MODE_DIM    = 2'd3
    } mode_t;

    localparam int NUM_MODES = 4;

endpackage

// File: rtl/key_led_ctrl_debounce.sv
// One push-button channel: 2-flop synchronizer, stability counter,
// debounced level and a single-cycle press pulse on each accepted 0->1.
module key_debounce #(
    parameter int DEB_CNT        = 8192,
    parameter bit KEY_ACTIVE_LOW = 1'b0
) (
    input  logic clk_50m,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CNT - 1);

    logic [1:0]       sync;
    logic             synced;
    logic [CNT_W-1:0] cnt;

    assign synced = sync[1] ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            press <= 1'b0;
            if (synced == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // counter only runs while synced differs, so synced=1 here means a press
                cnt   <= '0;
                level <= synced;
                press <= synced;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_led_ctrl.sv
// Debounced push-buttons step an LED pattern mode; patterns advance on a
// power-of-two tick derived from a free-running counter.
//
//   state       | meaning
//   MODE_BLINK  | all LEDs follow phase, toggling each tick
//   MODE_WALK_L | single lit LED moving upward each tick
//   MODE_WALK_R | single lit LED moving downward each tick
//   MODE_DIM    | all LEDs on for 4 of every 16 cycles
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int NUM_KEYS       = 2,
    parameter int NUM_LEDS       = 4,
    parameter int DEB_CNT        = 8192,
    parameter int TICK_W         = 26,   // must be >= 3 so counter[3:0] exists
    parameter bit KEY_ACTIVE_LOW = 1'b0
) (
    input  logic                clk_50m,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led,
    output logic                heartbeat
);

    localparam int POS_W = $clog2(NUM_LEDS);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_debounce #(
            .DEB_CNT        (DEB_CNT),
            .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
        ) u_debounce (
            .clk_50m (clk_50m),
            .rst_n   (rst_n),
            .key     (key[g]),
            .level   (key_level[g]),
            .press   (key_press[g])
        );
    end

    logic [TICK_W:0] tick_cnt;
    logic            tick;
    logic            dim_on;

    always_ff @(posedge clk_50m) begin
        if (!rst_n) tick_cnt <= '0;
        else        tick_cnt <= tick_cnt + (TICK_W+1)'(1);
    end

    assign tick      = &tick_cnt[TICK_W-1:0];
    assign heartbeat = tick_cnt[TICK_W];
    assign dim_on    = (tick_cnt[3:0] < 4'd4);

    mode_t               mode_q, mode_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    logic                phase_q, phase_d;
    logic [NUM_LEDS-1:0] led_d;
    logic                step_up, step_dn;

    assign step_up = key_press[0] & ~key_press[1];
    assign step_dn = key_press[1] & ~key_press[0];

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            mode_q  <= MODE_BLINK;
            pos_q   <= '0;
            phase_q <= 1'b0;
            led     <= '0;
        end else begin
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            phase_q <= phase_d;
            led     <= led_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        pos_d   = pos_q;
        phase_d = phase_q;
        led_d   = '0;

        if (step_up)      mode_d = mode_t'(mode_q + 2'd1);
        else if (step_dn) mode_d = mode_t'(mode_q - 2'd1);

        // a mode change restarts the pattern and swallows a coincident tick
        if (step_up || step_dn) begin
            phase_d = 1'b0;
            pos_d   = (mode_d == MODE_WALK_R) ? POS_LAST : '0;
        end else if (tick) begin
            phase_d = ~phase_q;
            case (mode_q)
                MODE_WALK_L: pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
                MODE_WALK_R: pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
                default:     pos_d = pos_q;
            endcase
        end

        case (mode_q)
            MODE_BLINK:  led_d = {NUM_LEDS{phase_q}};
            MODE_WALK_L,
            MODE_WALK_R: led_d[pos_q] = 1'b1;
            MODE_DIM:    led_d = {NUM_LEDS{dim_on}};
            default:     led_d = '0;
        endcase
    end

    assign mode = mode_q;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Scoreboard bench for key_led_ctrl: stimulus feeds a window-rule key model
// that queues expected events; a negedge monitor pops and compares.
module tb_key_led_ctrl;

    localparam int NK  = 3;
    localparam int NL  = 4;
    localparam int DEB = 8;
    localparam int TW  = 4;
    localparam int PER = 1 << TW;

    logic          clk_50m = 1'b0;
    logic          rst_n   = 1'b0;
    logic [NK-1:0] key     = '0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [1:0]    mode;
    logic [NL-1:0] led;
    logic          heartbeat;

    key_led_ctrl #(
        .NUM_KEYS       (NK),
        .NUM_LEDS       (NL),
        .DEB_CNT        (DEB),
        .TICK_W         (TW),
        .KEY_ACTIVE_LOW (1'b0)
    ) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .key       (key),
        .key_level (key_level),
        .key_press (key_press),
        .mode      (mode),
        .led       (led),
        .heartbeat (heartbeat)
    );

    always #10 clk_50m = ~clk_50m;

    // edges completed since reset was released
    int cyc = 0;
    always @(posedge clk_50m) begin
        if (!rst_n) cyc = 0;
        else        cyc = cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cyc=%0d: actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int at;
        int md;
    } mev_t;

    logic [NK-1:0] hist[$];
    logic [NK-1:0] m_lvl;
    int            m_mode;
    int            lvl_q[NK][$];
    int            press_q[NK][$];
    mev_t          mode_q[$];
    mev_t          mode_hist[$];

    task automatic model_reset();
        hist.delete();
        m_lvl  = '0;
        m_mode = 0;
        for (int i = 0; i < NK; i++) begin
            lvl_q[i].delete();
            press_q[i].delete();
        end
        mode_q.delete();
        mode_hist.delete();
        mode_hist.push_back('{0, 0});
    endtask

    // A key value driven unbroken for DEB cycles ending in cycle c is accepted
    // at edge c+3 (two synchronizer stages plus the accepting edge).
    task automatic model_cycle(logic [NK-1:0] k);
        int            c;
        logic [NK-1:0] pr;
        bit            all_v;
        logic          b;
        c  = cyc;
        pr = '0;
        hist.push_back(k);
        for (int i = 0; i < NK; i++) begin
            if (k[i] != m_lvl[i]) begin
                all_v = 1'b1;
                for (int j = c - DEB + 1; j <= c; j++) begin
                    b = (j < 0) ? 1'b0 : hist[j][i];
                    if (b != k[i]) all_v = 1'b0;
                end
                if (all_v) begin
                    m_lvl[i] = k[i];
                    lvl_q[i].push_back(c + 3);
                    if (k[i]) begin
                        pr[i] = 1'b1;
                        press_q[i].push_back(c + 3);
                    end
                end
            end
        end
        if (pr[0] != pr[1]) begin
            m_mode = pr[0] ? (m_mode + 1) % 4 : (m_mode + 3) % 4;
            mode_q.push_back('{c + 4, m_mode});
            mode_hist.push_back('{c + 4, m_mode});
        end
    endtask

    // LED after edge k follows the state left by edge k-1: ticks land on
    // edges that are multiples of PER, excluding the mode-change edge itself.
    function automatic int exp_led(int k);
        int mm, at, t;
        mm = 0;
        at = 0;
        for (int x = mode_hist.size() - 1; x >= 0; x--) begin
            if (mode_hist[x].at <= k - 1) begin
                mm = mode_hist[x].md;
                at = mode_hist[x].at;
                break;
            end
        end
        t = (k - 1) / PER - at / PER;
        case (mm)
            0:       return (t % 2 == 1) ? (1 << NL) - 1 : 0;
            1:       return 1 << (t % NL);
            2:       return (1 << (NL - 1)) >> (t % NL);
            default: return ((k - 1) % 16 < 4) ? (1 << NL) - 1 : 0;
        endcase
    endfunction

    task automatic step(logic [NK-1:0] k);
        @(posedge clk_50m);
        #1;
        key = k;
        model_cycle(k);
    endtask

    task automatic hold(logic [NK-1:0] k, int n);
        repeat (n) step(k);
    endtask

    task automatic do_reset(int n);
        @(posedge clk_50m);
        #1;
        rst_n = 1'b0;
        repeat (n - 1) @(posedge clk_50m);
        @(posedge clk_50m);
        #1;
        rst_n = 1'b1;
        model_reset();
        model_cycle(key);
    endtask

    logic [NK-1:0] exp_lvl;
    logic [NK-1:0] prev_lvl;
    int            exp_mode;
    int            prev_mode;
    int            k_now;
    bit            due;

    always @(negedge clk_50m) begin
        if (rst_n) begin
            k_now = cyc;
            if (k_now == 0) begin
                check("reset_key_level", int'(key_level), 0);
                check("reset_key_press", int'(key_press), 0);
                check("reset_mode", int'(mode), 0);
                check("reset_led", int'(led), 0);
                check("reset_heartbeat", int'(heartbeat), 0);
                exp_lvl   = '0;
                prev_lvl  = '0;
                exp_mode  = 0;
                prev_mode = 0;
            end else begin
                for (int i = 0; i < NK; i++) begin
                    due = (lvl_q[i].size() > 0) && (lvl_q[i][0] == k_now);
                    if (due) begin
                        exp_lvl[i] = ~exp_lvl[i];
                        void'(lvl_q[i].pop_front());
                    end
                    if (due || key_level[i] != prev_lvl[i])
                        check($sformatf("key_level[%0d]", i), int'(key_level[i]), int'(exp_lvl[i]));
                    prev_lvl[i] = key_level[i];

                    due = (press_q[i].size() > 0) && (press_q[i][0] == k_now);
                    if (due) void'(press_q[i].pop_front());
                    if (due || key_press[i])
                        check($sformatf("key_press[%0d]", i), int'(key_press[i]), int'(due));
                end

                due = (mode_q.size() > 0) && (mode_q[0].at == k_now);
                if (due) begin
                    exp_mode = mode_q[0].md;
                    void'(mode_q.pop_front());
                end
                if (due || int'(mode) != prev_mode)
                    check("mode", int'(mode), exp_mode);
                prev_mode = int'(mode);

                check("led", int'(led), exp_led(k_now));
                check("heartbeat", int'(heartbeat), (k_now >> TW) & 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    logic [NK-1:0] kv;
    int            rem[NK];

    initial begin
        model_reset();
        do_reset(3);
        hold(3'b000, 5);

        // short glitch on key 0: must be ignored
        hold(3'b001, 5);
        hold(3'b000, 15);

        // clean press of key 0 -> WALK_L, then let it walk several ticks
        hold(3'b001, 20);
        hold(3'b000, 80);

        // key 1 twice: WALK_L -> BLINK -> DIM
        repeat (2) begin
            hold(3'b010, 12);
            hold(3'b000, 12);
        end
        hold(3'b000, 40);

        // DIM -> BLINK, then key 1 -> DIM, then both together: stays DIM
        hold(3'b001, 12);
        hold(3'b000, 12);
        hold(3'b010, 12);
        hold(3'b000, 12);
        hold(3'b011, 12);
        hold(3'b000, 12);

        // three key-0 presses: DIM -> BLINK -> WALK_L -> WALK_R
        repeat (3) begin
            hold(3'b001, 12);
            hold(3'b000, 12);
        end
        hold(3'b000, 30);

        // reset in the middle of a key-2 debounce
        hold(3'b100, 4);
        do_reset(1);
        hold(3'b100, 20);
        hold(3'b000, 20);

        // randomized segments: short glitches and long holds per key
        kv = '0;
        for (int i = 0; i < NK; i++) rem[i] = 0;
        for (int cc = 0; cc < 2400; cc++) begin
            if (cc == 1200) do_reset(1 + int'($urandom_range(0, 2)));
            for (int i = 0; i < NK; i++) begin
                if (rem[i] == 0) begin
                    kv[i]  = ~kv[i];
                    rem[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, DEB - 2))
                                                         : int'($urandom_range(DEB, DEB + 30));
                end
                rem[i] = rem[i] - 1;
            end
            step(kv);
        end

        hold(3'b000, 40);
        for (int i = 0; i < NK; i++) begin
            check($sformatf("pending_press[%0d]", i), press_q[i].size(), 0);
            check($sformatf("pending_level[%0d]", i), lvl_q[i].size(), 0);
        end
        check("pending_mode", mode_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
